// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared types and constants for the rhythm-game scoring path.
//   game_state_t      : IDLE / PLAY / OVER encoding seen on game_state
//   KEY_START/KEY_ESC : keyboard codes that start and abort a game
//   SCORE_MAX         : saturation ceiling that keeps score within 4 BCD digits
//   COMBO_T1..T3      : combo thresholds where the multiplier steps up
//   combo_mult()      : maps a combo count to its 1..4 score multiplier
package rhythm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam logic [7:0]  KEY_START = 8'h2c;
    localparam logic [7:0]  KEY_ESC   = 8'h01;
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    localparam logic [7:0]  COMBO_T1  = 8'd10;
    localparam logic [7:0]  COMBO_T2  = 8'd20;
    localparam logic [7:0]  COMBO_T3  = 8'd30;

    function automatic logic [2:0] combo_mult(input logic [7:0] c);
        if (c >= COMBO_T3)      return 3'd4;
        else if (c >= COMBO_T2) return 3'd3;
        else if (c >= COMBO_T1) return 3'd2;
        else                    return 3'd1;
    endfunction

endpackage

// File: rtl/bin2bcd14.sv
// bin2bcd14: combinational double-dabble, 14-bit binary to four BCD digits.
//   bin : binary value, expected 0..9999 (larger values lose the 5th digit)
//   bcd : {thousands, hundreds, tens, ones}
module bin2bcd14 (
    input  logic [13:0] bin,
    output logic [15:0] bcd
);

    logic [15:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 13; i >= 0; i--) begin
            // Correct each digit before the shift so it carries correctly
            for (int d = 0; d < 4; d++) begin
                if (acc[d*4 +: 4] >= 4'd5)
                    acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
            end
            acc = {acc[14:0], bin[i]};
        end
        bcd = acc;
    end

endmodule

// File: rtl/note_scoreboard.sv
// note_scoreboard: turns per-lane hit/miss levels from the note droppers into
// game results (score with combo multiplier, combo tracking, hit/miss counts)
// and sequences the game through IDLE -> PLAY -> OVER.
//   frame_clk  : frame clock, all state updates on rising edge
//   Reset      : synchronous active-high reset
//   keycode    : keyboard code (KEY_START begins a game, KEY_ESC aborts)
//   hit, miss  : per-lane judgement levels, one rising edge counted per lane
//   score      : binary score, saturating at SCORE_MAX
//   score_bcd  : registered BCD of score (one frame behind score)
//   combo      : current consecutive-hit count, saturating at 255
//   max_combo  : highest combo reached this game
//   hits       : lanes resolved as hit
//   misses     : lanes resolved as miss
//   game_state : 0 IDLE, 1 PLAY, 2 OVER
module note_scoreboard
    import rhythm_pkg::*;
#(
    parameter int NUM_NOTES = 32,
    parameter int PTS_HIT   = 10,
    parameter int CNT_W     = 6
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [NUM_NOTES-1:0] hit,
    input  logic [NUM_NOTES-1:0] miss,
    output logic [13:0]          score,
    output logic [15:0]          score_bcd,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo,
    output logic [CNT_W-1:0]     hits,
    output logic [CNT_W-1:0]     misses,
    output logic [1:0]           game_state
);

    localparam int PC_W = $clog2(NUM_NOTES + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_NOTES-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_NOTES; i++)
            n = n + PC_W'(v[i]);
        return n;
    endfunction

    game_state_t state_q, next_state;

    logic [NUM_NOTES-1:0] hit_q, miss_q, resolved_q;
    logic [13:0]          score_q;
    logic [15:0]          bcd_q;
    logic [7:0]           combo_q, max_q;
    logic [CNT_W-1:0]     hits_q, misses_q;

    logic [NUM_NOTES-1:0] new_hit, new_miss;
    logic [PC_W-1:0]      nh, nm;
    logic [2:0]           mult;
    logic [14:0]          gain, score_sum;
    logic [13:0]          score_next;
    logic [8:0]           combo_sum;
    logic [7:0]           cand;
    logic [15:0]          bcd_comb;
    logic                 clear_all;

    // ---------------- FSM ----------------
    always_ff @(posedge frame_clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE: if (keycode == KEY_START) next_state = PLAY;
            PLAY: begin
                if (keycode == KEY_ESC)  next_state = IDLE;
                else if (&resolved_q)    next_state = OVER;
            end
            OVER: if (keycode == KEY_ESC) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- per-frame judgement ----------------
    always_comb begin
        // A lane rising on both hit and miss in one frame counts as a hit
        new_hit   = hit  & ~hit_q  & ~resolved_q;
        new_miss  = miss & ~miss_q & ~resolved_q & ~new_hit;
        nh        = popcount(new_hit);
        nm        = popcount(new_miss);
        // Multiplier comes from the combo held at the start of the frame
        mult      = combo_mult(combo_q);
        gain      = 15'(nh) * 15'(PTS_HIT) * 15'(mult);
        score_sum = {1'b0, score_q} + gain;
        score_next = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
        combo_sum = {1'b0, combo_q} + 9'(nh);
        cand      = combo_sum[8] ? 8'd255 : combo_sum[7:0];
    end

    assign clear_all = Reset || (state_q != IDLE && next_state == IDLE);

    bin2bcd14 u_bcd (
        .bin (score_q),
        .bcd (bcd_comb)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge frame_clk) begin
        if (clear_all) begin
            hit_q      <= '0;
            miss_q     <= '0;
            resolved_q <= '0;
            score_q    <= '0;
            bcd_q      <= '0;
            combo_q    <= '0;
            max_q      <= '0;
            hits_q     <= '0;
            misses_q   <= '0;
        end else begin
            bcd_q <= bcd_comb;
            case (state_q)
                IDLE: begin
                    // Levels already high at game start must not count as edges
                    hit_q  <= (next_state == PLAY) ? hit  : '0;
                    miss_q <= (next_state == PLAY) ? miss : '0;
                end
                PLAY: begin
                    hit_q      <= hit;
                    miss_q     <= miss;
                    resolved_q <= resolved_q | new_hit | new_miss;
                    score_q    <= score_next;
                    if (cand > max_q) max_q <= cand;
                    combo_q    <= (nm != '0) ? 8'd0 : cand;
                    hits_q     <= hits_q   + CNT_W'(nh);
                    misses_q   <= misses_q + CNT_W'(nm);
                end
                default: ; // OVER: results held, inputs ignored
            endcase
        end
    end

    assign score      = score_q;
    assign score_bcd  = bcd_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;
    assign hits       = hits_q;
    assign misses     = misses_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_note_scoreboard.sv
// tb_note_scoreboard: directed scenario tests for note_scoreboard.
module tb_note_scoreboard;

    logic        frame_clk;
    logic        Reset;
    logic [7:0]  keycode;
    logic [31:0] hit, miss;
    logic [13:0] score;
    logic [15:0] score_bcd;
    logic [7:0]  combo, max_combo;
    logic [5:0]  hits, misses;
    logic [1:0]  game_state;

    int tests = 0;
    int fails = 0;

    note_scoreboard #(.NUM_NOTES(32), .PTS_HIT(10), .CNT_W(6)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .score_bcd  (score_bcd),
        .combo      (combo),
        .max_combo  (max_combo),
        .hits       (hits),
        .misses     (misses),
        .game_state (game_state)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    // Abort the current game and start a fresh one with all inputs low
    task automatic restart();
        hit = '0; miss = '0;
        keycode = 8'h01; step();
        keycode = 8'h2c; step();
        keycode = 8'h00;
    endtask

    task automatic test_reset();
        Reset = 1'b1; keycode = 8'h00; hit = '0; miss = '0;
        step(2);
        Reset = 1'b0;
        step();
        tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL reset state: got %0d want 0", game_state); end
        tests++; if (score !== 14'd0 || combo !== 8'd0 || hits !== 6'd0 || misses !== 6'd0 || score_bcd !== 16'h0) begin
            fails++; $display("FAIL reset outputs: score=%0d combo=%0d hits=%0d misses=%0d bcd=%h want all 0", score, combo, hits, misses, score_bcd); end
    endtask

    task automatic test_start();
        keycode = 8'h2c; step(); keycode = 8'h00;
        tests++; if (game_state !== 2'd1) begin fails++; $display("FAIL start state: got %0d want 1", game_state); end
        tests++; if (score !== 14'd0 || combo !== 8'd0 || hits !== 6'd0 || misses !== 6'd0) begin
            fails++; $display("FAIL start outputs: score=%0d combo=%0d hits=%0d misses=%0d want 0", score, combo, hits, misses); end
    endtask

    task automatic test_single_hit();
        hit[5] = 1'b1; step();
        tests++; if (score !== 14'd10 || combo !== 8'd1 || hits !== 6'd1) begin
            fails++; $display("FAIL single_hit edge: score=%0d combo=%0d hits=%0d want 10/1/1", score, combo, hits); end
        step(9);
        tests++; if (score !== 14'd10 || combo !== 8'd1 || hits !== 6'd1) begin
            fails++; $display("FAIL single_hit held: score=%0d combo=%0d hits=%0d want 10/1/1", score, combo, hits); end
    endtask

    task automatic test_combo_mult();
        restart();
        for (int i = 0; i < 12; i++) begin
            hit[i] = 1'b1; step();
        end
        tests++; if (score !== 14'd140) begin fails++; $display("FAIL combo_mult score: got %0d want 140", score); end
        tests++; if (combo !== 8'd12 || max_combo !== 8'd12) begin
            fails++; $display("FAIL combo_mult combo: combo=%0d max=%0d want 12/12", combo, max_combo); end
        tests++; if (score_bcd !== 16'h0120) begin fails++; $display("FAIL bcd_lag: got %h want 0120", score_bcd); end
        step();
        tests++; if (score_bcd !== 16'h0140) begin fails++; $display("FAIL bcd: got %h want 0140", score_bcd); end
    endtask

    task automatic test_same_frame();
        restart();
        hit[0] = 1'b1; hit[1] = 1'b1; miss[2] = 1'b1; step();
        tests++; if (score !== 14'd20 || combo !== 8'd0 || max_combo !== 8'd2) begin
            fails++; $display("FAIL same_frame score/combo: score=%0d combo=%0d max=%0d want 20/0/2", score, combo, max_combo); end
        tests++; if (hits !== 6'd2 || misses !== 6'd1) begin
            fails++; $display("FAIL same_frame counts: hits=%0d misses=%0d want 2/1", hits, misses); end
    endtask

    task automatic test_hit_miss_tie();
        hit[7] = 1'b1; miss[7] = 1'b1; step();
        tests++; if (hits !== 6'd3 || misses !== 6'd1 || score !== 14'd30 || combo !== 8'd1) begin
            fails++; $display("FAIL tie: hits=%0d misses=%0d score=%0d combo=%0d want 3/1/30/1", hits, misses, score, combo); end
        miss[7] = 1'b0; step();
        miss[7] = 1'b1; step();
        tests++; if (misses !== 6'd1 || combo !== 8'd1) begin
            fails++; $display("FAIL tie_retoggle: misses=%0d combo=%0d want 1/1", misses, combo); end
    endtask

    task automatic test_game_over();
        hit = '1; step();
        tests++; if (hits !== 6'd31 || score !== 14'd310 || combo !== 8'd29 || max_combo !== 8'd29) begin
            fails++; $display("FAIL all_lanes: hits=%0d score=%0d combo=%0d max=%0d want 31/310/29/29", hits, score, combo, max_combo); end
        tests++; if (game_state !== 2'd1) begin fails++; $display("FAIL over_early: got %0d want 1", game_state); end
        step();
        tests++; if (game_state !== 2'd2) begin fails++; $display("FAIL over_state: got %0d want 2", game_state); end
        hit = '0; miss = '0; step(); hit = '1; miss = '1; step();
        tests++; if (hits !== 6'd31 || misses !== 6'd1 || score !== 14'd310 || game_state !== 2'd2) begin
            fails++; $display("FAIL over_hold: hits=%0d misses=%0d score=%0d state=%0d want 31/1/310/2", hits, misses, score, game_state); end
        keycode = 8'h01; step(); keycode = 8'h00;
        tests++; if (game_state !== 2'd0 || score !== 14'd0 || combo !== 8'd0 || max_combo !== 8'd0 ||
                     hits !== 6'd0 || misses !== 6'd0 || score_bcd !== 16'h0) begin
            fails++; $display("FAIL esc_clear: state=%0d score=%0d combo=%0d max=%0d hits=%0d misses=%0d bcd=%h want all 0",
                              game_state, score, combo, max_combo, hits, misses, score_bcd); end
        hit = '0; miss = '0;
    endtask

    task automatic test_reset_mid_play();
        restart();
        for (int i = 0; i < 5; i++) begin
            hit[i] = 1'b1; step();
        end
        tests++; if (score !== 14'd50 || game_state !== 2'd1) begin
            fails++; $display("FAIL pre_reset: score=%0d state=%0d want 50/1", score, game_state); end
        Reset = 1'b1; step(); Reset = 1'b0;
        tests++; if (game_state !== 2'd0 || score !== 14'd0 || hits !== 6'd0 || combo !== 8'd0) begin
            fails++; $display("FAIL reset_mid_play: state=%0d score=%0d hits=%0d combo=%0d want 0", game_state, score, hits, combo); end
        hit = '0;
    endtask

    task automatic test_preloaded_lane();
        // A lane already high when the game starts is not an edge
        hit = 32'h0000_0100;
        keycode = 8'h2c; step(); keycode = 8'h00;
        step(2);
        tests++; if (hits !== 6'd0 || score !== 14'd0) begin
            fails++; $display("FAIL preloaded: hits=%0d score=%0d want 0/0", hits, score); end
        hit = '0;
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; hit = '0; miss = '0;
        test_reset();
        test_start();
        test_single_hit();
        test_combo_mult();
        test_same_frame();
        test_hit_miss_tie();
        test_game_over();
        test_reset_mid_play();
        test_preloaded_lane();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
